simon_sequencer: RTL and testbench

Parametrised Simon-style game sequencer: grows a random symbol sequence one entry per round, replays it to the display under control of an external timer pulse, then checks the player's inputs against it. Generalises the 2-bit, 32-deep game controller to any symbol width and depth. Adds explicit lit/blank display phases, a running score, a persistent high score, a proper win at full depth and an optional input timeout. Sits between the input encoder/RNG/timer blocks and the lamp/sound drivers.

---
 rtl/simon_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_simon_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/simon_sequencer.sv
// ---------------------------------------------------------------------------
// simon_sequencer : Simon-style game sequencer (grow / replay / check).
// Optional input timeout: define SIMON_TIMEOUT_EN.            Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module simon_sequencer #(
  parameter int SYM_W          = 2,
  parameter int DEPTH          = 32,
  parameter int TIMEOUT_PULSES = 8,
  localparam int CNT_W         = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [SYM_W-1:0] RAND,
  input  logic             TIMER_PULSE,
  input  logic [SYM_W-1:0] IN,
  input  logic             IN_VALID,
  output logic [SYM_W-1:0] OUT,
  output logic             OUT_VALID,
  output logic             INPUT_READY,
  output logic [CNT_W-1:0] SCORE,
  output logic [CNT_W-1:0] HIGH_SCORE,
  output logic             WIN,
  output logic             LOSE,
  output logic             HS
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADD      = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_OFF = 3'd3,
    S_INPUT    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] score_q, score_d;
  logic [CNT_W-1:0] high_score_q, high_score_d;
  logic             win_q, win_d;
  logic             hs_q, hs_d;
  logic             mem_we;
  logic [SYM_W-1:0] mem_q [DEPTH];
  logic [SYM_W-1:0] cur_sym;
  logic             at_last;

  assign cur_sym = mem_q[idx_q[ADDR_W-1:0]];
  assign at_last = (idx_q == len_q - CNT_W'(1));

`ifdef SIMON_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_PULSES + 1);
  logic [TO_W-1:0] tcnt_q, tcnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_PULSES > 0);
`endif

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    score_d      = score_q;
    high_score_d = high_score_q;
    win_d        = win_q;
    hs_d         = 1'b0;
    mem_we       = 1'b0;
`ifdef SIMON_TIMEOUT_EN
    // Counter only runs while waiting for the player; cleared everywhere else.
    tcnt_d       = (state_q == S_INPUT) ? tcnt_q : '0;
`endif
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        len_d = '0;
        if (START) begin
          score_d = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        mem_we  = 1'b1;
        len_d   = len_q + CNT_W'(1);
        idx_d   = '0;
        state_d = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (TIMER_PULSE) state_d = S_SHOW_OFF;
      end
      S_SHOW_OFF: begin
        if (TIMER_PULSE) begin
          if (at_last) begin
            idx_d   = '0;
            state_d = S_INPUT;
          end else begin
            idx_d   = idx_q + CNT_W'(1);
            state_d = S_SHOW_ON;
          end
        end
      end
      S_INPUT: begin
        if (IN_VALID) begin
`ifdef SIMON_TIMEOUT_EN
          tcnt_d = '0;
`endif
          if (IN == cur_sym) begin
            if (at_last) begin
              score_d = len_q;
              if (len_q == CNT_W'(DEPTH)) begin
                win_d   = 1'b1;
                state_d = S_DONE;
              end else begin
                state_d = S_ADD;
              end
            end else begin
              idx_d = idx_q + CNT_W'(1);
            end
          end else begin
            win_d   = 1'b0;
            state_d = S_DONE;
          end
        end
`ifdef SIMON_TIMEOUT_EN
        else if (TIMER_PULSE) begin
          if (tcnt_q == TO_W'(TIMEOUT_PULSES - 1)) begin
            win_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            tcnt_d = tcnt_q + TO_W'(1);
          end
        end
`endif
      end
      S_DONE: begin
        if (score_q > high_score_q) begin
          high_score_d = score_q;
          hs_d         = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      score_q      <= '0;
      high_score_q <= '0;
      win_q        <= 1'b0;
      hs_q         <= 1'b0;
`ifdef SIMON_TIMEOUT_EN
      tcnt_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      score_q      <= score_d;
      high_score_q <= high_score_d;
      win_q        <= win_d;
      hs_q         <= hs_d;
`ifdef SIMON_TIMEOUT_EN
      tcnt_q       <= tcnt_d;
`endif
    end
  end

  // Sequence storage is deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[len_q[ADDR_W-1:0]] <= RAND;
  end

  assign OUT         = (state_q == S_SHOW_ON || state_q == S_SHOW_OFF) ? cur_sym : '0;
  assign OUT_VALID   = (state_q == S_SHOW_ON);
  assign INPUT_READY = (state_q == S_INPUT);
  assign SCORE       = score_q;
  assign HIGH_SCORE  = high_score_q;
  assign WIN         = (state_q == S_DONE) && win_q;
  assign LOSE        = (state_q == S_DONE) && !win_q;
  assign HS          = hs_q;

endmodule

`default_nettype wire

// File: tb/tb_simon_sequencer.sv
// ---------------------------------------------------------------------------
// tb_simon_sequencer : directed self-checking bench, DEPTH=4, SYM_W=2.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_simon_sequencer;

  localparam int SYM_W = 2;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             CLK;
  logic             RST_N;
  logic             START;
  logic [SYM_W-1:0] RAND;
  logic             TIMER_PULSE;
  logic [SYM_W-1:0] IN;
  logic             IN_VALID;
  logic [SYM_W-1:0] OUT;
  logic             OUT_VALID;
  logic             INPUT_READY;
  logic [CNT_W-1:0] SCORE;
  logic [CNT_W-1:0] HIGH_SCORE;
  logic             WIN;
  logic             LOSE;
  logic             HS;

  int tests  = 0;
  int failed = 0;
  int seq [DEPTH];

  simon_sequencer #(
    .SYM_W          (SYM_W),
    .DEPTH          (DEPTH),
    .TIMEOUT_PULSES (3)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .START       (START),
    .RAND        (RAND),
    .TIMER_PULSE (TIMER_PULSE),
    .IN          (IN),
    .IN_VALID    (IN_VALID),
    .OUT         (OUT),
    .OUT_VALID   (OUT_VALID),
    .INPUT_READY (INPUT_READY),
    .SCORE       (SCORE),
    .HIGH_SCORE  (HIGH_SCORE),
    .WIN         (WIN),
    .LOSE        (LOSE),
    .HS          (HS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse();
    TIMER_PULSE = 1'b1;
    step();
    TIMER_PULSE = 1'b0;
  endtask

  task automatic press(input int sym);
    IN       = 2'(sym);
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
  endtask

  // One lit and one blank interval per replayed symbol.
  task automatic show_sym(input int sym);
    check("show_on_valid", 32'(OUT_VALID), 1);
    check("show_on_sym", 32'(OUT), sym);
    check("show_on_not_ready", 32'(INPUT_READY), 0);
    pulse();
    check("show_off_valid", 32'(OUT_VALID), 0);
    check("show_off_hold", 32'(OUT), sym);
    pulse();
  endtask

  task automatic start_game();
    RAND  = 2'(seq[0]);
    START = 1'b1;
    step();
    START = 1'b0;
    check("add_score_clr", 32'(SCORE), 0);
    check("add_lamp_off", 32'(OUT_VALID), 0);
    step();
  endtask

  // Plays n_ok correct rounds; if n_ok < DEPTH the next round fails at fail_at.
  task automatic play_game(input int n_ok, input int fail_at, input int exp_hs, input int exp_high);
    int rounds;
    rounds = (n_ok == DEPTH) ? DEPTH : n_ok + 1;
    start_game();
    START = 1'b1; IN_VALID = 1'b1; IN = 2'(seq[0] + 1);
    step();
    START = 1'b0; IN_VALID = 1'b0;
    check("ignore_start_in_show", 32'(OUT_VALID), 1);
    for (int r = 1; r <= rounds; r++) begin
      for (int j = 0; j < r; j++) show_sym(seq[j]);
      check("input_ready", 32'(INPUT_READY), 1);
      for (int j = 0; j < r; j++) begin
        if (r == n_ok + 1 && j == fail_at) begin
          press((seq[j] + 1) % 4);
          break;
        end
        if (j == r - 1 && r < DEPTH) RAND = 2'(seq[r]);
        press(seq[j]);
        if (j < r - 1) check("input_ready_mid", 32'(INPUT_READY), 1);
      end
      if (r <= n_ok && r < DEPTH) begin
        check("add_score", 32'(SCORE), r);
        check("add_not_ready", 32'(INPUT_READY), 0);
        check("add_no_end", 32'({WIN, LOSE}), 0);
        step();
      end
    end
    check("done_win", 32'(WIN), (n_ok == DEPTH) ? 1 : 0);
    check("done_lose", 32'(LOSE), (n_ok == DEPTH) ? 0 : 1);
    check("done_score", 32'(SCORE), n_ok);
    check("done_hs_low", 32'(HS), 0);
    step();
    check("idle_hs", 32'(HS), exp_hs);
    check("idle_high", 32'(HIGH_SCORE), exp_high);
    check("idle_end_clr", 32'({WIN, LOSE}), 0);
    step();
    check("hs_one_cycle", 32'(HS), 0);
  endtask

  initial begin
    RST_N = 1'b0; START = 1'b0; RAND = '0; TIMER_PULSE = 1'b0; IN = '0; IN_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    check("reset_outs",
          32'({OUT, OUT_VALID, INPUT_READY, SCORE, HIGH_SCORE, WIN, LOSE, HS}), 0);
    repeat (10) step();
    check("idle10_outs",
          32'({OUT, OUT_VALID, INPUT_READY, SCORE, HIGH_SCORE, WIN, LOSE, HS}), 0);

    // Game A: round 3 fails on second input -> SCORE 2, new high score.
    seq = '{2, 1, 3, 0};
    play_game(2, 1, 1, 2);
    // Game B: round 2 fails on first input -> SCORE 1, high score stays 2.
    seq = '{3, 0, 1, 2};
    play_game(1, 0, 0, 2);

    // Game C: asynchronous reset while the lamp is lit.
    seq = '{1, 0, 0, 0};
    start_game();
    check("c_show_on", 32'(OUT_VALID), 1);
    RST_N = 1'b0;
    #1;
    check("rst_lamp_off", 32'(OUT_VALID), 0);
    check("rst_high_clr", 32'(HIGH_SCORE), 0);
    check("rst_idle", 32'({OUT, INPUT_READY, SCORE, WIN, LOSE, HS}), 0);
    #2;
    RST_N = 1'b1;
    step();

    // Game D: full-depth win.
    seq = '{1, 3, 0, 2};
    play_game(4, 0, 1, 4);

`ifdef SIMON_TIMEOUT_EN
    seq = '{1, 0, 0, 0};
    start_game();
    show_sym(1);
    pulse();
    pulse();
    check("to_still_ready", 32'(INPUT_READY), 1);
    pulse();
    check("to_lose", 32'(LOSE), 1);
    step();
    step();
    seq = '{2, 0, 0, 0};
    start_game();
    show_sym(2);
    pulse();
    pulse();
    IN = 2'd2; IN_VALID = 1'b1; TIMER_PULSE = 1'b1;
    step();
    IN_VALID = 1'b0; TIMER_PULSE = 1'b0;
    check("to_coinc_no_lose", 32'(LOSE), 0);
    check("to_coinc_score", 32'(SCORE), 1);
`else
    seq = '{1, 0, 0, 0};
    start_game();
    show_sym(1);
    repeat (5) pulse();
    check("no_to_ready", 32'(INPUT_READY), 1);
    check("no_to_lose", 32'(LOSE), 0);
    press(1);
    check("no_to_score", 32'(SCORE), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
